// File: rtl/fp6_reduce_sched.sv
// fp6_reduce_sched: round-robin scheduler sharing one FP6 adder tree and accumulator among requesters
module fp6_reduce_sched #(
  parameter int NUM_REQ = 4,
  parameter int BETA = 16,
  parameter int ADD_DATAWIDTH = 6,
  parameter int MAX_BEATS = 64,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int CNT_W = $clog2(MAX_BEATS + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*BETA*ADD_DATAWIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                      req_last,
  output logic [BETA*ADD_DATAWIDTH-1:0]           tree_idata,
  input  logic [ADD_DATAWIDTH-1:0]                tree_odata,
  output logic [ADD_DATAWIDTH-1:0]                acc_a,
  output logic [ADD_DATAWIDTH-1:0]                acc_b,
  input  logic [ADD_DATAWIDTH-1:0]                acc_o,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [ADD_DATAWIDTH-1:0]                res_data,
  output logic [ID_W-1:0]                         res_id,
  output logic [CNT_W-1:0]                        res_beats,
  output logic                                    res_ovf
);
  localparam int BW = BETA * ADD_DATAWIDTH;
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, gnt_nxt, grant_inc;
  logic [ID_W:0] idx;
  logic [ADD_DATAWIDTH-1:0] acc;
  logic [BW-1:0] in_reg;
  logic [CNT_W-1:0] cnt;
  logic in_vld, term, ovf, hs, fin, found, cnt_last;
  assign fin = state == RUN && in_vld && term;
  assign req_ready = (state == RUN && !(in_vld && term)) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant : '0;
  assign hs = req_valid[grant] && req_ready[grant];
  assign cnt_last = cnt == CNT_W'(MAX_BEATS - 1);
  assign grant_inc = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
  assign res_valid = state == OUT;
  assign tree_idata = in_reg;
  assign acc_a = acc;
  assign acc_b = tree_odata;
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_nxt = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        gnt_nxt = idx[ID_W-1:0];
      end
    end
  end
  // next state: grant from IDLE, finish after the terminating beat drains, release on result handshake
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && found) ? RUN :
                fin ? OUT :
                (state == OUT && res_ready) ? IDLE :
                (state != IDLE && state != RUN && state != OUT) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // beat capture, accumulation, result latch and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      grant <= '0;
      acc <= '0;
      in_reg <= '0;
      in_vld <= 1'b0;
      cnt <= '0;
      term <= 1'b0;
      ovf <= 1'b0;
      res_data <= '0;
      res_id <= '0;
      res_beats <= '0;
      res_ovf <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        grant <= gnt_nxt;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        term <= 1'b0;
        in_vld <= 1'b0;
      end
      if (state == RUN) begin
        in_vld <= hs;
        if (in_vld) acc <= acc_o;
        if (hs) begin
          in_reg <= req_data[int'(grant)*BW +: BW];
          cnt <= cnt + CNT_W'(1);
          term <= req_last[grant] || cnt_last;
          ovf <= cnt_last;
        end
      end
      if (fin) begin
        res_data <= acc_o;
        res_id <= grant;
        res_beats <= cnt;
        res_ovf <= ovf;
      end
      if (state == OUT && res_ready) rr_ptr <= grant_inc;
    end
  end
endmodule
